// File: rtl/udma_ext_per_arb_pkg.sv
// rtl/udma_ext_per_arb_pkg.sv - shared types and helpers for the external-peripheral TX arbiter
package udma_ext_per_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    LOCK = 2'd2
  } arb_state_e;

  // Width of a requester ID; never narrower than one bit
  function automatic int id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/udma_ext_per_id_fifo.sv
// rtl/udma_ext_per_id_fifo.sv - in-order FIFO of requester IDs for routing read returns
module udma_ext_per_id_fifo
  import udma_ext_per_arb_pkg::*;
#(
  parameter int ID_W  = 2,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_push,
  input  logic [ID_W-1:0] i_id,
  input  logic            i_pop,
  output logic            o_full,
  output logic            o_empty,
  output logic [ID_W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ID_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            w_do_push;
  logic            w_do_pop;

  // Fullness is evaluated before any same-cycle pop, so a full FIFO never accepts a push
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // ID storage; contents are don't-care while the count says empty
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_id;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/udma_ext_per_tx_arbiter.sv
// rtl/udma_ext_per_tx_arbiter.sv - round-robin burst arbiter for the uDMA TX read channel (option: EXT_PER_ARB_PRIO_EN)
module udma_ext_per_tx_arbiter
  import udma_ext_per_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int BURST_LEN       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [2*N_REQ-1:0] datasize_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   valid_o,
  input  logic [N_REQ-1:0]   ready_i,
`ifdef EXT_PER_ARB_PRIO_EN
  input  logic [N_REQ-1:0]   prio_i,
`endif
  output logic [31:0]        data_o,
  output logic               data_tx_req_o,
  input  logic               data_tx_gnt_i,
  output logic [1:0]         data_tx_datasize_o,
  input  logic [31:0]        data_tx_i,
  input  logic               data_tx_valid_i,
  output logic               data_tx_ready_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int BCW   = $clog2(BURST_LEN + 1);

  arb_state_e      r_state;
  arb_state_e      w_next_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_win;
  logic [BCW-1:0]  r_burst_cnt;
  logic            r_err;

  logic [ID_W-1:0] w_arb_pick;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [ID_W-1:0] w_head;
  logic            w_prio_exit;

  // First set bit of mask searching upward from ptr+1, wrapping modulo N_REQ
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + 1 + k) % N_REQ;
      if (!found && mask[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    return pick;
  endfunction

`ifdef EXT_PER_ARB_PRIO_EN
  logic [N_REQ-1:0] w_prio_req;
  assign w_prio_req  = req_i & prio_i;
  // Priority requesters are searched first; the rest only when none is pending
  assign w_arb_pick  = (|w_prio_req) ? rr_pick(w_prio_req, r_rr_ptr) : rr_pick(req_i, r_rr_ptr);
  // A non-priority owner yields as soon as a priority request shows up
  assign w_prio_exit = ~prio_i[r_win] & (|w_prio_req);
`else
  assign w_arb_pick  = rr_pick(req_i, r_rr_ptr);
  assign w_prio_exit = 1'b0;
`endif

  // Next-state and forward-path outputs; the channel is only driven while an owner holds it
  always_comb begin
    w_next_state       = r_state;
    data_tx_req_o      = 1'b0;
    data_tx_datasize_o = 2'b00;
    gnt_o              = '0;
    w_push             = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_i) w_next_state = ARB;
      end
      ARB: begin
        w_next_state = (|req_i) ? LOCK : IDLE;
      end
      LOCK: begin
        data_tx_req_o      = req_i[r_win] & ~w_full;
        data_tx_datasize_o = datasize_i[{r_win, 1'b0} +: 2];
        w_push             = data_tx_req_o & data_tx_gnt_i;
        gnt_o[r_win]       = w_push;
        if (!req_i[r_win] || (w_push && (r_burst_cnt == BCW'(BURST_LEN - 1))) || w_prio_exit) begin
          w_next_state = ARB;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, owner, burst counter and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ARB && (|req_i)) begin
        r_win       <= w_arb_pick;
        r_burst_cnt <= '0;
      end
      if (r_state == LOCK) begin
        if (w_push) r_burst_cnt <= r_burst_cnt + 1'b1;
        if (w_next_state == ARB) r_rr_ptr <= r_win;
      end
    end
  end

  // Return path steered by the oldest outstanding ID; stray data is accepted and dropped
  always_comb begin
    valid_o = '0;
    if (data_tx_valid_i && !w_empty) valid_o[w_head] = 1'b1;
    data_tx_ready_o = w_empty ? data_tx_valid_i : ready_i[w_head];
  end

  assign w_pop  = data_tx_valid_i & data_tx_ready_o & ~w_empty;
  assign data_o = data_tx_i;
  assign busy_o = (r_state != IDLE) | ~w_empty;
  assign err_o  = r_err;

  // Sticky flag for data arriving with nothing outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (data_tx_valid_i && w_empty) begin
      r_err <= 1'b1;
    end
  end

  udma_ext_per_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_id    (r_win),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_udma_ext_per_tx_arbiter.sv
// tb/tb_udma_ext_per_tx_arbiter.sv - directed self-checking bench for the TX arbiter
module tb_udma_ext_per_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [7:0]  datasize_i;
  logic [3:0]  gnt_o;
  logic [3:0]  valid_o;
  logic [3:0]  ready_i;
`ifdef EXT_PER_ARB_PRIO_EN
  logic [3:0]  prio_i;
`endif
  logic [31:0] data_o;
  logic        data_tx_req_o;
  logic        data_tx_gnt_i;
  logic [1:0]  data_tx_datasize_o;
  logic [31:0] data_tx_i;
  logic        data_tx_valid_i;
  logic        data_tx_ready_o;
  logic        busy_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  udma_ext_per_tx_arbiter #(
    .N_REQ           (4),
    .BURST_LEN       (4),
    .MAX_OUTSTANDING (4)
  ) u_dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .req_i              (req_i),
    .datasize_i         (datasize_i),
    .gnt_o              (gnt_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
`ifdef EXT_PER_ARB_PRIO_EN
    .prio_i             (prio_i),
`endif
    .data_o             (data_o),
    .data_tx_req_o      (data_tx_req_o),
    .data_tx_gnt_i      (data_tx_gnt_i),
    .data_tx_datasize_o (data_tx_datasize_o),
    .data_tx_i          (data_tx_i),
    .data_tx_valid_i    (data_tx_valid_i),
    .data_tx_ready_o    (data_tx_ready_o),
    .busy_o             (busy_o),
    .err_o              (err_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic zero_inputs();
    req_i           = 4'b0000;
    ready_i         = 4'b0000;
    data_tx_gnt_i   = 1'b0;
    data_tx_valid_i = 1'b0;
    data_tx_i       = 32'h0;
`ifdef EXT_PER_ARB_PRIO_EN
    prio_i          = 4'b0000;
`endif
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
  endtask

  // Drive one cycle of inputs, check settled outputs, then advance past the next edge
  task automatic cyc(input string tag, input logic [3:0] rq, input logic g, input logic v,
                     input logic [3:0] rd, input logic e_req, input logic [3:0] e_gnt,
                     input logic [3:0] e_val, input logic e_rdy, input logic [1:0] e_ds);
    req_i           = rq;
    data_tx_gnt_i   = g;
    data_tx_valid_i = v;
    ready_i         = rd;
    #1;
    check({tag, ".req"},  {31'd0, data_tx_req_o}, {31'd0, e_req});
    check({tag, ".gnt"},  {28'd0, gnt_o},         {28'd0, e_gnt});
    check({tag, ".val"},  {28'd0, valid_o},       {28'd0, e_val});
    check({tag, ".rdy"},  {31'd0, data_tx_ready_o}, {31'd0, e_rdy});
    check({tag, ".ds"},   {30'd0, data_tx_datasize_o}, {30'd0, e_ds});
    @(posedge clk);
    #1;
  endtask

  int         q[$];
  int         own;
  logic [3:0] eg;
  logic [3:0] ev;
  logic       vld;

  initial begin
    rst_i      = 1'b1;
    datasize_i = 8'hE4;   // requester i uses datasize i
    zero_inputs();
    do_reset();

    // Reset state
    check("rst.req",  {31'd0, data_tx_req_o}, 32'd0);
    check("rst.gnt",  {28'd0, gnt_o},         32'd0);
    check("rst.val",  {28'd0, valid_o},       32'd0);
    check("rst.rdy",  {31'd0, data_tx_ready_o}, 32'd0);
    check("rst.busy", {31'd0, busy_o},        32'd0);
    check("rst.err",  {31'd0, err_o},         32'd0);

    // Single requester: two bursts of 4 with one ARB cycle between, returns overlapping
    data_tx_i = 32'hCAFE_0001;
    cyc("t1.c0",  4'b0001, 1, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t1.c1",  4'b0001, 1, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t1.c2",  4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 4'b0000, 0, 2'd0);
    cyc("t1.c3",  4'b0001, 1, 1, 4'b0001, 1, 4'b0001, 4'b0001, 1, 2'd0);
    check("t1.data", data_o, 32'hCAFE_0001);
    cyc("t1.c4",  4'b0001, 1, 1, 4'b0001, 1, 4'b0001, 4'b0001, 1, 2'd0);
    cyc("t1.c5",  4'b0001, 1, 1, 4'b0001, 1, 4'b0001, 4'b0001, 1, 2'd0);
    cyc("t1.c6",  4'b0001, 1, 1, 4'b0001, 0, 4'b0000, 4'b0001, 1, 2'd0);
    cyc("t1.c7",  4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 4'b0000, 0, 2'd0);
    cyc("t1.c8",  4'b0001, 1, 1, 4'b0001, 1, 4'b0001, 4'b0001, 1, 2'd0);
    cyc("t1.c9",  4'b0001, 1, 1, 4'b0001, 1, 4'b0001, 4'b0001, 1, 2'd0);
    cyc("t1.c10", 4'b0001, 1, 1, 4'b0001, 1, 4'b0001, 4'b0001, 1, 2'd0);
    cyc("t1.c11", 4'b0000, 1, 1, 4'b0001, 0, 4'b0000, 4'b0001, 1, 2'd0);
    zero_inputs();
    #1;
    check("t1.busy", {31'd0, busy_o}, 32'd0);
    check("t1.err",  {31'd0, err_o},  32'd0);

    // All requesting: round-robin from rr_ptr+1, 4 grants per owner, returns in issue order
    do_reset();
    q.delete();
    for (int k = 0; k < 21; k++) begin
      vld = (q.size() > 0);
      ev  = vld ? 4'(1 << q[0]) : 4'b0000;
      own = (1 + (k - 1) / 5) % 4;
      eg  = (k >= 1 && ((k - 1) % 5) != 0) ? 4'(1 << own) : 4'b0000;
      data_tx_i = 32'(k);
      cyc("t2", 4'b1111, 1, vld, 4'b1111, (eg != 0), eg, ev, vld,
          ((k - 1) % 5 != 0 && k >= 1) ? 2'(own) : 2'd0);
      if (vld) void'(q.pop_front());
      if (eg != 0) q.push_back(own);
    end
    cyc("t2.end", 4'b0000, 1, 1, 4'b1111, 0, 4'b0000, 4'b0001, 1, 2'd0);
    check("t2.err", {31'd0, err_o}, 32'd0);

    // FIFO full: request gated until one return frees a slot
    do_reset();
    cyc("t3.d0",  4'b0001, 1, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t3.d1",  4'b0001, 1, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t3.d2",  4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 4'b0000, 0, 2'd0);
    cyc("t3.d3",  4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 4'b0000, 1, 2'd0);
    cyc("t3.d4",  4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 4'b0000, 1, 2'd0);
    cyc("t3.d5",  4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 4'b0000, 1, 2'd0);
    cyc("t3.d6",  4'b0001, 1, 0, 4'b0001, 0, 4'b0000, 4'b0000, 1, 2'd0);
    cyc("t3.d7",  4'b0001, 1, 0, 4'b0001, 0, 4'b0000, 4'b0000, 1, 2'd0);
    cyc("t3.d8",  4'b0001, 1, 0, 4'b0001, 0, 4'b0000, 4'b0000, 1, 2'd0);
    cyc("t3.d9",  4'b0001, 1, 1, 4'b0001, 0, 4'b0000, 4'b0001, 1, 2'd0);
    cyc("t3.d10", 4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 4'b0000, 1, 2'd0);
    cyc("t3.d11", 4'b0001, 1, 0, 4'b0001, 0, 4'b0000, 4'b0000, 1, 2'd0);

    // Returns for IDs 2 then 0, with requester 2 stalling for 3 cycles
    do_reset();
    cyc("t4.e0",  4'b0100, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t4.e1",  4'b0100, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t4.e2",  4'b0100, 1, 0, 4'b0000, 1, 4'b0100, 4'b0000, 0, 2'd2);
    cyc("t4.e3",  4'b0001, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd2);
    cyc("t4.e4",  4'b0001, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t4.e5",  4'b0001, 1, 0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 2'd0);
    cyc("t4.e6",  4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 4'b0100, 0, 2'd0);
    cyc("t4.e7",  4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 4'b0100, 0, 2'd0);
    cyc("t4.e8",  4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 4'b0100, 0, 2'd0);
    check("t4.busy", {31'd0, busy_o}, 32'd1);
    data_tx_i = 32'h0000_0A02;
    cyc("t4.e9",  4'b0000, 0, 1, 4'b0100, 0, 4'b0000, 4'b0100, 1, 2'd0);
    cyc("t4.e10", 4'b0000, 0, 1, 4'b0001, 0, 4'b0000, 4'b0001, 1, 2'd0);
    cyc("t4.e11", 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    check("t4.idle", {31'd0, busy_o}, 32'd0);

    // Stray data with nothing outstanding: accepted, sticky error
    cyc("t5.f0",  4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 1, 2'd0);
    check("t5.err1", {31'd0, err_o}, 32'd1);
    cyc("t5.f1",  4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t5.f2",  4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    check("t5.err2", {31'd0, err_o}, 32'd1);
    do_reset();
    check("t5.clr", {31'd0, err_o}, 32'd0);

    // Asynchronous reset mid-LOCK with 2 outstanding, then late data flags an error
    cyc("t6.h0",  4'b0001, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t6.h1",  4'b0001, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("t6.h2",  4'b0001, 1, 0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 2'd0);
    cyc("t6.h3",  4'b0001, 1, 0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 2'd0);
    #1;
    check("t6.pre", {31'd0, data_tx_req_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("t6.req",  {31'd0, data_tx_req_o}, 32'd0);
    check("t6.gnt",  {28'd0, gnt_o},         32'd0);
    check("t6.busy", {31'd0, busy_o},        32'd0);
    zero_inputs();
    @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    cyc("t6.late", 4'b0000, 0, 1, 4'b0001, 0, 4'b0000, 4'b0000, 1, 2'd0);
    check("t6.err", {31'd0, err_o}, 32'd1);

`ifdef EXT_PER_ARB_PRIO_EN
    // Priority requester 3 wins first although rr order would pick 1
    do_reset();
    prio_i = 4'b1000;
    cyc("p.i0", 4'b1111, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("p.i1", 4'b1111, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
    cyc("p.i2", 4'b1111, 1, 0, 4'b0000, 1, 4'b1000, 4'b0000, 0, 2'd3);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
